// File: rtl/rmw_ram_engine_pkg.sv
// Shared definitions for the read-modify-write RAM engine.
//   op_e    : modify operation applied to every word of a sweep
//   state_e : engine FSM states
package rmw_ram_engine_pkg;

  typedef enum logic [1:0] {
    OP_ADD   = 2'd0,  // word + operand, wrapping at 2^WIDTH
    OP_XOR   = 2'd1,  // word ^ operand
    OP_CLEAR = 2'd2,  // word := 0
    OP_NOP   = 2'd3   // word rewritten unchanged
  } op_e;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_READ   = 2'd1,
    ST_WRITE  = 2'd2,
    ST_FINISH = 2'd3
  } state_e;

endpackage

// File: rtl/rmw_ram_engine_if.sv
// Control and host bus of the read-modify-write RAM engine.
//   start/base_addr/len/op/operand : sweep request, sampled while ready=1
//   ready/done                     : idle indication and completion pulse
//   host_we/host_addr/host_wdata   : direct RAM access while idle
//   host_rdata                     : RAM data, one cycle after host_addr
// master = sequencer/host side, slave = engine side.
interface rmw_ram_engine_if
  import rmw_ram_engine_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int DEPTH = 16
);
  localparam int AW = $clog2(DEPTH);
  localparam int LW = $clog2(DEPTH) + 1;

  logic             start;
  logic [AW-1:0]    base_addr;
  logic [LW-1:0]    len;
  op_e              op;
  logic [WIDTH-1:0] operand;
  logic             ready;
  logic             done;
  logic             host_we;
  logic [AW-1:0]    host_addr;
  logic [WIDTH-1:0] host_wdata;
  logic [WIDTH-1:0] host_rdata;

  modport master (
    output start, base_addr, len, op, operand, host_we, host_addr, host_wdata,
    input  ready, done, host_rdata
  );

  modport slave (
    input  start, base_addr, len, op, operand, host_we, host_addr, host_wdata,
    output ready, done, host_rdata
  );

endinterface

// File: rtl/rmw_ram_engine_ram.sv
// sp_sync_ram: single-port RAM, synchronous write, registered read.
//   clk     : clock
//   we_i    : write enable
//   addr_i  : word address (shared by read and write)
//   wdata_i : write data
//   rdata_o : data at addr_i from the previous edge (read-before-write)
module sp_sync_ram #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 16,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             we_i,
  input  logic [AW-1:0]    addr_i,
  input  logic [WIDTH-1:0] wdata_i,
  output logic [WIDTH-1:0] rdata_o
);

  logic [WIDTH-1:0] mem_q [DEPTH];

  always_ff @(posedge clk) begin
    if (we_i) begin
      mem_q[addr_i] <= wdata_i;
    end
    rdata_o <= mem_q[addr_i];
  end

endmodule

// File: rtl/rmw_ram_engine.sv
// rmw_ram_engine: owns a single-port RAM and, on start, applies ADD/XOR/
// CLEAR/NOP to len consecutive words starting at base_addr (wrapping).
//   clk : clock
//   rst : synchronous active-high reset
//   bus : slave side of rmw_ram_engine_if (sweep control + host port)
// The RAM port belongs to the host while idle and to the FSM otherwise.
module rmw_ram_engine
  import rmw_ram_engine_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int DEPTH = 16,
  localparam int AW   = $clog2(DEPTH),
  localparam int LW   = $clog2(DEPTH) + 1
) (
  input  logic clk,
  input  logic rst,
  rmw_ram_engine_if.slave bus
);

  state_e           state_q, state_d;
  logic [AW-1:0]    addr_q, addr_d;
  logic [LW-1:0]    cnt_q, cnt_d;
  op_e              op_q, op_d;
  logic [WIDTH-1:0] operand_q, operand_d;
  logic             done_q, done_d;
  logic             host_sel_q;   // last RAM read was issued by the host
  logic [WIDTH-1:0] host_hold_q;  // host read data held while busy

  logic             ram_we;
  logic [AW-1:0]    ram_addr;
  logic [WIDTH-1:0] ram_wdata;
  logic [WIDTH-1:0] ram_rdata;
  logic [WIDTH-1:0] mod_data;
  logic [LW-1:0]    len_clamped;

  assign len_clamped = (bus.len > LW'(DEPTH)) ? LW'(DEPTH) : bus.len;

  sp_sync_ram #(.WIDTH(WIDTH), .DEPTH(DEPTH), .AW(AW)) u_ram (
    .clk     (clk),
    .we_i    (ram_we),
    .addr_i  (ram_addr),
    .wdata_i (ram_wdata),
    .rdata_o (ram_rdata)
  );

  // State and datapath registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      addr_q      <= '0;
      cnt_q       <= '0;
      op_q        <= OP_ADD;
      operand_q   <= '0;
      done_q      <= 1'b0;
      host_sel_q  <= 1'b0;
      host_hold_q <= '0;
    end else begin
      state_q    <= state_d;
      addr_q     <= addr_d;
      cnt_q      <= cnt_d;
      op_q       <= op_d;
      operand_q  <= operand_d;
      done_q     <= done_d;
      host_sel_q <= (state_q == ST_IDLE);
      if (host_sel_q) begin
        host_hold_q <= ram_rdata;
      end
    end
  end

  // Next-state logic.
  always_comb begin
    state_d   = state_q;
    addr_d    = addr_q;
    cnt_d     = cnt_q;
    op_d      = op_q;
    operand_d = operand_q;
    done_d    = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (bus.start) begin
          addr_d    = bus.base_addr;
          op_d      = bus.op;
          operand_d = bus.operand;
          if (bus.len != '0) begin
            cnt_d   = len_clamped;
            state_d = ST_READ;
          end else begin
            // Empty sweep dwells two cycles so it matches a one-word sweep.
            cnt_d   = LW'(1);
            state_d = ST_FINISH;
          end
        end
      end
      ST_READ: begin
        state_d = ST_WRITE;
      end
      ST_WRITE: begin
        addr_d = addr_q + AW'(1);  // power-of-two depth wraps naturally
        cnt_d  = cnt_q - LW'(1);
        if (cnt_q == LW'(1)) begin
          state_d = ST_IDLE;
          done_d  = 1'b1;
        end else begin
          state_d = ST_READ;
        end
      end
      ST_FINISH: begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - LW'(1);
        end else begin
          state_d = ST_IDLE;
          done_d  = 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Outputs and RAM port mux.
  always_comb begin
    unique case (op_q)
      OP_ADD:   mod_data = ram_rdata + operand_q;
      OP_XOR:   mod_data = ram_rdata ^ operand_q;
      OP_CLEAR: mod_data = '0;
      default:  mod_data = ram_rdata;
    endcase
    // rst gates writes so a reset edge never commits a half-done sweep word.
    ram_we    = !rst && (((state_q == ST_IDLE) && bus.host_we) || (state_q == ST_WRITE));
    ram_addr  = (state_q == ST_IDLE) ? bus.host_addr : addr_q;
    ram_wdata = (state_q == ST_IDLE) ? bus.host_wdata : mod_data;
  end

  assign bus.ready      = (state_q == ST_IDLE);
  assign bus.done       = done_q;
  assign bus.host_rdata = host_sel_q ? ram_rdata : host_hold_q;

endmodule

// File: tb/tb_rmw_ram_engine.sv
module tb_rmw_ram_engine;
  import rmw_ram_engine_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   errors = 0;
  int   checks = 0;

  always #5 clk = ~clk;

  rmw_ram_engine_if #(.WIDTH(16), .DEPTH(16)) bus ();

  rmw_ram_engine #(.WIDTH(16), .DEPTH(16)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct {
    logic [3:0]  addr;
    logic [15:0] init;
    op_e         op;
    logic [15:0] operand;
    logic [15:0] exp_val;
  } vec_t;

  vec_t vecs[5];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h required 0x%0h", name, act, exp);
    end
  endtask

  task automatic host_write(input logic [3:0] a, input logic [15:0] d);
    bus.host_we    = 1'b1;
    bus.host_addr  = a;
    bus.host_wdata = d;
    tick();
    bus.host_we    = 1'b0;
    $display("host write addr=%0d data=0x%04h", a, d);
  endtask

  task automatic host_check(input string name, input logic [3:0] a, input logic [15:0] exp);
    bus.host_addr = a;
    tick();
    $display("host read  addr=%0d data=0x%04h", a, bus.host_rdata);
    check(name, {16'h0, bus.host_rdata}, {16'h0, exp});
  endtask

  task automatic do_start(input logic [3:0] base, input logic [4:0] l, input op_e o,
                          input logic [15:0] operand);
    bus.start     = 1'b1;
    bus.base_addr = base;
    bus.len       = l;
    bus.op        = o;
    bus.operand   = operand;
    tick();
    bus.start     = 1'b0;
    $display("start base=%0d len=%0d op=%0d operand=0x%04h", base, l, o, operand);
  endtask

  // Called right after the start edge; counts edges until done shows.
  task automatic wait_done(input string name, input int exp_cycles, input int already);
    int c = already;
    bit busy_ok = 1'b1;
    while (!bus.done && c < 200) begin
      if (bus.ready) busy_ok = 1'b0;
      tick();
      c++;
    end
    $display("sweep %s done after %0d cycles", name, c);
    check({name, " latency"}, c, exp_cycles);
    check({name, " busy"}, {31'h0, busy_ok}, 32'h1);
    check({name, " ready@done"}, {31'h0, bus.ready}, 32'h1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout required completion");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.start = 1'b0; bus.base_addr = '0; bus.len = '0; bus.op = OP_ADD;
    bus.operand = '0; bus.host_we = 1'b0; bus.host_addr = '0; bus.host_wdata = '0;

    vecs[0] = '{4'd3,  16'h0005, OP_ADD,   16'h0002, 16'h0007};
    vecs[1] = '{4'd5,  16'hFFFF, OP_ADD,   16'h0003, 16'h0002};
    vecs[2] = '{4'd7,  16'h1234, OP_XOR,   16'hFFFF, 16'hEDCB};
    vecs[3] = '{4'd9,  16'hBEEF, OP_CLEAR, 16'h1234, 16'h0000};
    vecs[4] = '{4'd10, 16'hCAFE, OP_NOP,   16'h1111, 16'hCAFE};

    // Reset.
    rst = 1'b1;
    tick();
    check("reset ready", {31'h0, bus.ready}, 32'h1);
    check("reset done", {31'h0, bus.done}, 32'h0);
    check("reset rdata", {16'h0, bus.host_rdata}, 32'h0);
    rst = 1'b0;
    tick();
    check("idle ready", {31'h0, bus.ready}, 32'h1);
    check("idle done", {31'h0, bus.done}, 32'h0);

    // Single-word sweeps from the table.
    for (int i = 0; i < 5; i++) begin
      host_write(vecs[i].addr, vecs[i].init);
      do_start(vecs[i].addr, 5'd1, vecs[i].op, vecs[i].operand);
      wait_done($sformatf("vec%0d", i), 2, 0);
      tick();
      check($sformatf("vec%0d done pulse", i), {31'h0, bus.done}, 32'h0);
      host_check($sformatf("vec%0d result", i), vecs[i].addr, vecs[i].exp_val);
    end

    // Wrap-around XOR sweep.
    host_write(4'd14, 16'h00F0);
    host_write(4'd15, 16'h000F);
    host_write(4'd0,  16'h1111);
    host_write(4'd1,  16'hAAAA);
    do_start(4'd14, 5'd3, OP_XOR, 16'h00FF);
    wait_done("wrap", 6, 0);
    host_check("wrap a14", 4'd14, 16'h000F);
    host_check("wrap a15", 4'd15, 16'h00F0);
    host_check("wrap a0",  4'd0,  16'h11EE);
    host_check("wrap a1",  4'd1,  16'hAAAA);

    // Empty sweep: CLEAR op must not touch memory.
    do_start(4'd0, 5'd0, OP_CLEAR, 16'h0000);
    wait_done("len0", 2, 0);
    host_check("len0 a0", 4'd0, 16'h11EE);
    host_check("len0 a1", 4'd1, 16'hAAAA);

    // Busy-port rejection, then back-to-back start in the done cycle.
    host_write(4'd0, 16'h0001);
    host_write(4'd1, 16'h0002);
    host_write(4'd2, 16'h0003);
    host_write(4'd3, 16'h0004);
    do_start(4'd0, 5'd4, OP_CLEAR, 16'h0000);
    bus.host_we = 1'b1; bus.host_addr = 4'd2; bus.host_wdata = 16'h5555;
    bus.start = 1'b1; bus.base_addr = 4'd5; bus.len = 5'd1; bus.op = OP_CLEAR;
    for (int k = 0; k < 6; k++) tick();
    bus.host_we = 1'b0; bus.start = 1'b0;
    wait_done("clear4", 8, 6);
    bus.start = 1'b1; bus.base_addr = 4'd0; bus.len = 5'd1; bus.op = OP_ADD;
    bus.operand = 16'h0007;
    tick();
    bus.start = 1'b0;
    check("b2b ready", {31'h0, bus.ready}, 32'h0);
    wait_done("b2b", 2, 0);
    host_check("b2b a0", 4'd0, 16'h0007);
    host_check("clear a1", 4'd1, 16'h0000);
    host_check("clear a2", 4'd2, 16'h0000);
    host_check("clear a3", 4'd3, 16'h0000);
    host_check("ignored start a5", 4'd5, 16'h0002);

    // Reset mid-sweep.
    host_write(4'd0, 16'h0000);
    do_start(4'd0, 5'd4, OP_ADD, 16'h0001);
    for (int k = 0; k < 3; k++) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("midrst ready", {31'h0, bus.ready}, 32'h1);
    check("midrst done", {31'h0, bus.done}, 32'h0);
    host_check("midrst a0", 4'd0, 16'h0001);
    host_check("midrst a1", 4'd1, 16'h0000);
    host_check("midrst a2", 4'd2, 16'h0000);
    host_check("midrst a3", 4'd3, 16'h0000);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
